// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the pipeline/multi-cycle unit side (master) and the
// register-file write arbiter (slave).
//  a_*            : writeback-stage write request, a_stall back-pressure
//  b_*            : multi-cycle unit valid/ready write request
//  regWrite*      : registered register-file write port
//  pend_mask      : registers targeted by queued B entries (hazard unit)
//  fifo_count     : number of queued B entries
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_NUM_WIDTH = 5,
    parameter int unsigned DEPTH         = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                     a_we;
    logic [REG_NUM_WIDTH-1:0] a_num;
    logic [DATA_WIDTH-1:0]    a_data;
    logic                     a_stall;

    logic                     b_valid;
    logic                     b_ready;
    logic [REG_NUM_WIDTH-1:0] b_num;
    logic [DATA_WIDTH-1:0]    b_data;

    logic                     regWriteEnable;
    logic [REG_NUM_WIDTH-1:0] regWriteNum;
    logic [DATA_WIDTH-1:0]    regWriteData;
    logic [31:0]              pend_mask;
    logic [CNT_W-1:0]         fifo_count;

    modport master (
        output a_we, a_num, a_data, b_valid, b_num, b_data,
        input  a_stall, b_ready, regWriteEnable, regWriteNum, regWriteData,
               pend_mask, fifo_count
    );

    modport slave (
        input  a_we, a_num, a_data, b_valid, b_num, b_data,
        output a_stall, b_ready, regWriteEnable, regWriteNum, regWriteData,
               pend_mask, fifo_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the in-order writeback
// stage (port A, priority) and a multi-cycle unit (port B, valid/ready).
// B results are queued in a FIFO and drained when A is idle; a starvation
// counter forces one A-stall cycle so a waiting head always drains.
//  clk   : clock, all state on posedge
//  reset : asynchronous, active-low
//  bus   : slave modport of regfile_write_arbiter_if (A/B requests, write
//          port, pend_mask, fifo_count)
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned REG_NUM_WIDTH = 5,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned STARVE_LIMIT  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned NREG  = 32;

    logic [REG_NUM_WIDTH-1:0] num_q  [DEPTH];
    logic [DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [STV_W-1:0]         starve_q, starve_d;
    logic                     b_ready_q, b_ready_d;
    logic                     we_q, we_d;
    logic [REG_NUM_WIDTH-1:0] wnum_q, wnum_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [NREG-1:0]          pend_q, pend_d;
    logic [REG_NUM_WIDTH-1:0] slot_num;

    logic nonempty_c, a_req_c, stall_c, pop_c, push_c;

    // Request decode: writes to x0 are not requests on either port.
    always_comb begin
        nonempty_c = (count_q != '0);
        a_req_c    = bus.a_we && (bus.a_num != '0);
        stall_c    = nonempty_c && (starve_q >= STV_W'(STARVE_LIMIT));
        pop_c      = nonempty_c && (stall_c || !a_req_c);
        push_c     = bus.b_valid && b_ready_q && (bus.b_num != '0);
    end

    // Next-state: FIFO bookkeeping, starvation counter, write selection.
    always_comb begin
        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q + PTR_W'(push_c);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop_c);
        count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        // Registered ready: a full FIFO only reopens the cycle after a pop.
        b_ready_d = (count_d < CNT_W'(DEPTH));
        starve_d  = starve_q;
        we_d      = 1'b0;
        wnum_d    = wnum_q;
        wdata_d   = wdata_q;
        pend_d    = '0;
        slot_num  = '0;

        if (pop_c) valid_d[rd_ptr_q] = 1'b0;
        if (push_c) valid_d[wr_ptr_q] = 1'b1;

        if (pop_c || !nonempty_c) begin
            starve_d = '0;
        end else if (starve_q < STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
        end

        if (pop_c) begin
            we_d    = 1'b1;
            wnum_d  = num_q[rd_ptr_q];
            wdata_d = data_q[rd_ptr_q];
        end else if (a_req_c) begin
            we_d    = 1'b1;
            wnum_d  = bus.a_num;
            wdata_d = bus.a_data;
        end

        // Mask reflects the post-edge FIFO contents, including a slot being pushed.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot_num = (push_c && (wr_ptr_q == PTR_W'(i))) ? bus.b_num : num_q[i];
            if (valid_d[i]) pend_d[slot_num] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            b_ready_q <= 1'b0;
            we_q      <= 1'b0;
            wnum_q    <= '0;
            wdata_q   <= '0;
            pend_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            b_ready_q <= b_ready_d;
            we_q      <= we_d;
            wnum_q    <= wnum_d;
            wdata_q   <= wdata_d;
            pend_q    <= pend_d;
        end
    end

    // FIFO payload storage; validity is tracked separately so no reset needed.
    always_ff @(posedge clk) begin
        if (push_c) begin
            num_q[wr_ptr_q]  <= bus.b_num;
            data_q[wr_ptr_q] <= bus.b_data;
        end
    end

    assign bus.a_stall        = stall_c;
    assign bus.b_ready        = b_ready_q;
    assign bus.regWriteEnable = we_q;
    assign bus.regWriteNum    = wnum_q;
    assign bus.regWriteData   = wdata_q;
    assign bus.pend_mask      = pend_q;
    assign bus.fifo_count     = count_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed vector table, hand-written
// multi-cycle sequences and random traffic checked against a queue model.
module tb_regfile_write_arbiter;
    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 4;
    localparam int LIM   = 8;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW), .DEPTH(DEPTH)) bif ();

    regfile_write_arbiter #(
        .DATA_WIDTH(DW), .REG_NUM_WIDTH(RW), .DEPTH(DEPTH), .STARVE_LIMIT(LIM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of pending B writes plus expected write port.
    typedef struct {
        logic [RW-1:0] num;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    int            m_starve;
    logic          m_we;
    logic [RW-1:0] m_num;
    logic [DW-1:0] m_data;
    logic          m_rdy;

    function void model_reset();
        mq.delete();
        m_starve = 0;
        m_we     = 1'b0;
        m_num    = '0;
        m_data   = '0;
        m_rdy    = 1'b0;
    endfunction

    function logic m_stall();
        return (mq.size() != 0) && (m_starve >= LIM);
    endfunction

    function logic [31:0] m_pend();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].num] = 1'b1;
        return p;
    endfunction

    // One clock edge of the arbitration rules, applied to the current inputs.
    function void model_step();
        ent_t e;
        bit   nonempty, stall, areq, popped;
        nonempty = (mq.size() != 0);
        stall    = nonempty && (m_starve >= LIM);
        areq     = bif.a_we && (bif.a_num != 0);
        popped   = 0;
        if (stall || (nonempty && !areq)) begin
            e      = mq.pop_front();
            m_we   = 1'b1;
            m_num  = e.num;
            m_data = e.data;
            popped = 1;
        end else if (areq) begin
            m_we   = 1'b1;
            m_num  = bif.a_num;
            m_data = bif.a_data;
        end else begin
            m_we = 1'b0;
        end
        if (bif.b_valid && m_rdy && (bif.b_num != 0)) begin
            e.num  = bif.b_num;
            e.data = bif.b_data;
            mq.push_back(e);
        end
        if (popped || !nonempty) m_starve = 0;
        else if (m_starve < LIM) m_starve = m_starve + 1;
        m_rdy = (mq.size() < DEPTH);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".stall"}, 32'(bif.a_stall), 32'(m_stall()));
        chk({tag, ".rdy"},   32'(bif.b_ready), 32'(m_rdy));
        chk({tag, ".we"},    32'(bif.regWriteEnable), 32'(m_we));
        chk({tag, ".num"},   32'(bif.regWriteNum), 32'(m_num));
        chk({tag, ".data"},  bif.regWriteData, m_data);
        chk({tag, ".cnt"},   32'(bif.fifo_count), 32'(mq.size()));
        chk({tag, ".pend"},  bif.pend_mask, m_pend());
    endtask

    // Inputs change just after a falling edge; outputs are sampled 1ns later.
    task automatic apply(input logic aw, input logic [RW-1:0] an, input logic [DW-1:0] ad,
                         input logic bv, input logic [RW-1:0] bn, input logic [DW-1:0] bd);
        bif.a_we    = aw;
        bif.a_num   = an;
        bif.a_data  = ad;
        bif.b_valid = bv;
        bif.b_num   = bn;
        bif.b_data  = bd;
        #1;
    endtask

    task automatic advance();
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic          aw;
        logic [RW-1:0] an;
        logic [DW-1:0] ad;
        logic          bv;
        logic [RW-1:0] bn;
        logic [DW-1:0] bd;
        logic          e_stall;
        logic          e_rdy;
        logic          e_we;
        logic [RW-1:0] e_num;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_cnt;
        logic [31:0]   e_pend;
    } vec_t;

    vec_t vt[9];

    initial begin
        // Rows start right after reset release; expectations are outputs seen
        // with that row's inputs applied, before the following edge.
        vt[0] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0};
        vt[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd0, 32'h0};
        vt[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        3'd1, 32'h20};
        vt[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 3'd0, 32'h0};
        vt[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h123,      1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 3'd0, 32'h0};
        vt[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 3'd0, 32'h0};
        vt[6] = '{1'b1, 5'd3, 32'hAAAA,     1'b1, 5'd7, 32'h11,       1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 3'd0, 32'h0};
        vt[7] = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd3, 32'hAAAA,     3'd1, 32'h80};
        vt[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 5'd7, 32'h11,       3'd0, 32'h0};

        reset = 1'b0;
        model_reset();
        apply(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            apply(vt[i].aw, vt[i].an, vt[i].ad, vt[i].bv, vt[i].bn, vt[i].bd);
            chk($sformatf("vec%0d.stall", i), 32'(bif.a_stall), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d.rdy", i),   32'(bif.b_ready), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d.we", i),    32'(bif.regWriteEnable), 32'(vt[i].e_we));
            chk($sformatf("vec%0d.num", i),   32'(bif.regWriteNum), 32'(vt[i].e_num));
            chk($sformatf("vec%0d.data", i),  bif.regWriteData, vt[i].e_data);
            chk($sformatf("vec%0d.cnt", i),   32'(bif.fifo_count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d.pend", i),  bif.pend_mask, vt[i].e_pend);
            advance();
        end

        // FIFO fills under continuous A traffic; the fifth push must wait.
        begin
            int acc = 0;
            for (int c = 0; c < 12; c++) begin
                apply(1'b1, RW'(c % 31 + 1), $urandom, (acc < 5), RW'(20 + acc), 32'hB000_0000 + acc);
                if (c == 4) begin
                    chk("full.rdy", 32'(bif.b_ready), 32'd0);
                    chk("full.cnt", 32'(bif.fifo_count), 32'd4);
                end
                check_model($sformatf("fill%0d", c));
                if (bif.b_valid && m_rdy) acc++;
                advance();
            end
        end
        for (int c = 0; c < 10; c++) begin
            apply(0, 0, 0, 0, 0, 0);
            check_model($sformatf("drain%0d", c));
            advance();
        end

        // Starvation: one queued head under continuous A writes.
        apply(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hCAFE0009);
        check_model("starve.push");
        advance();
        for (int j = 0; j <= 8; j++) begin
            apply(1'b1, 5'd10, 32'hA0A0, 0, 0, 0);
            chk($sformatf("starve.stall%0d", j), 32'(bif.a_stall), (j == 8) ? 32'd1 : 32'd0);
            check_model($sformatf("starve%0d", j));
            advance();
        end
        apply(1'b1, 5'd10, 32'hA0A0, 0, 0, 0);
        chk("starve.head_we",   32'(bif.regWriteEnable), 32'd1);
        chk("starve.head_num",  32'(bif.regWriteNum), 32'd9);
        chk("starve.head_data", bif.regWriteData, 32'hCAFE0009);
        chk("starve.restall",   32'(bif.a_stall), 32'd0);
        advance();
        apply(0, 0, 0, 0, 0, 0);
        chk("starve.a_we",   32'(bif.regWriteEnable), 32'd1);
        chk("starve.a_num",  32'(bif.regWriteNum), 32'd10);
        chk("starve.a_data", bif.regWriteData, 32'hA0A0);
        advance();

        // Asynchronous reset with three entries queued.
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 5'd1, 32'h77, 1'b1, RW'(11 + k), 32'hD000_0000 + k);
            check_model($sformatf("prerst%0d", k));
            advance();
        end
        apply(1'b1, 5'd2, 32'h88, 0, 0, 0);
        check_model("prerst3");
        chk("prerst.cnt", 32'(bif.fifo_count), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("rst.stall", 32'(bif.a_stall), 32'd0);
        chk("rst.rdy",   32'(bif.b_ready), 32'd0);
        chk("rst.we",    32'(bif.regWriteEnable), 32'd0);
        chk("rst.num",   32'(bif.regWriteNum), 32'd0);
        chk("rst.data",  bif.regWriteData, 32'd0);
        chk("rst.cnt",   32'(bif.fifo_count), 32'd0);
        chk("rst.pend",  bif.pend_mask, 32'd0);
        model_reset();
        apply(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        apply(0, 0, 0, 0, 0, 0);
        chk("rel.rdy0", 32'(bif.b_ready), 32'd0);
        advance();
        apply(0, 0, 0, 0, 0, 0);
        chk("rel.rdy1", 32'(bif.b_ready), 32'd1);
        check_model("rel");
        advance();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            apply(($urandom_range(0, 99) < 60), RW'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 99) < 50), RW'($urandom_range(0, 31)), $urandom);
            check_model($sformatf("rnd%0d", c));
            advance();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
